// File: rtl/fc_pkg.sv
// Shared definitions for the fully connected layer read sequencers:
// state encoding, layer dimensions and the weight address helper.
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WRITE,
        DONE
    } fc_state_t;

    localparam int FC1_N_IN  = 16;
    localparam int FC1_N_OUT = 10;

    localparam int FC1_P2_AW  = $clog2(FC1_N_IN);
    localparam int FC1_W_AW   = $clog2(FC1_N_IN * FC1_N_OUT);
    localparam int FC1_OUT_AW = $clog2(FC1_N_OUT);

    // Deepest memory read latency the sequencer is built to cover.
    localparam int FC_MEM_LAT_MAX = 3;

    // Weight memory is laid out neuron-major: row n holds that neuron's inputs.
    function automatic int fcWeightIndex(input int n, input int i, input int nIn);
        return n * nIn + i;
    endfunction

endpackage

// File: rtl/fc1_mem_read_if.sv
// Bus between the FC1 read sequencer and the memories / MAC it controls.
// The sequencer is the slave side: it takes start and drives everything else.
interface fc1_mem_read_if
    import fc_pkg::*;
#(
    parameter int N_IN  = FC1_N_IN,
    parameter int N_OUT = FC1_N_OUT
);

    localparam int P2_AW  = $clog2(N_IN);
    localparam int W_AW   = $clog2(N_IN * N_OUT);
    localparam int OUT_AW = $clog2(N_OUT);

    logic              start;
    logic [P2_AW-1:0]  p2_addr;
    logic [W_AW-1:0]   w_addr;
    logic              rd_en;
    logic              acc_clr;
    logic              acc_en;
    logic              out_wr;
    logic [OUT_AW-1:0] out_addr;
    logic              busy;
    logic              done;

    modport slave (
        input  start,
        output p2_addr,
        output w_addr,
        output rd_en,
        output acc_clr,
        output acc_en,
        output out_wr,
        output out_addr,
        output busy,
        output done
    );

    modport master (
        output start,
        input  p2_addr,
        input  w_addr,
        input  rd_en,
        input  acc_clr,
        input  acc_en,
        input  out_wr,
        input  out_addr,
        input  busy,
        input  done
    );

endinterface

// File: rtl/fc_valid_pipe.sv
// Delay line that carries {valid, clear} from the read issue point to the
// MAC, matching the read latency of the activation and weight memories.
module fc_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_din,
    output logic [1:0] o_dout
);

    logic [1:0] r_stage [DEPTH];

    // Shift one stage per clock; reset flushes every stage so no stale strobe escapes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= 2'b00;
            end
        end else begin
            r_stage[0] <= i_din;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign o_dout = r_stage[DEPTH-1];

endmodule

// File: rtl/fc1_mem_read.sv
// FC1 read sequencer: for every output neuron, streams all pooled
// activations with the matching weight address, then lets the last product
// drain through the memory latency and issues one result write.
// Every output is a register; the FSM computes next-cycle output values
// alongside the next state so nothing combinational reaches a port.
module fc1_mem_read
    import fc_pkg::*;
#(
    parameter int N_IN    = FC1_N_IN,
    parameter int N_OUT   = FC1_N_OUT,
    parameter int MEM_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    fc1_mem_read_if.slave  bus
);

    localparam int P2_AW  = $clog2(N_IN);
    localparam int W_AW   = $clog2(N_IN * N_OUT);
    localparam int OUT_AW = $clog2(N_OUT);

    fc_state_t         r_state;
    logic [P2_AW-1:0]  r_i;
    logic [OUT_AW-1:0] r_n;
    logic [1:0]        r_drain;

    logic              r_rdEn;
    logic [P2_AW-1:0]  r_p2Addr;
    logic [W_AW-1:0]   r_wAddr;
    logic              r_outWr;
    logic [OUT_AW-1:0] r_outAddr;
    logic              r_busy;
    logic              r_done;

    logic [P2_AW-1:0]  w_nextI;
    logic [W_AW-1:0]   w_nextWAddr;
    logic [W_AW-1:0]   w_nextRowAddr;
    logic [1:0]        w_pipeIn;
    logic [1:0]        w_pipeOut;

    // Addresses for the next read are formed from the registered counters,
    // so the multiply sits between flops and never sees a wrapped value.
    assign w_nextI       = r_i + 1'b1;
    assign w_nextWAddr   = W_AW'(fcWeightIndex(int'(r_n), int'(w_nextI), N_IN));
    assign w_nextRowAddr = W_AW'(fcWeightIndex(int'(r_n) + 1, 0, N_IN));

    // The first read of a neuron is the one at activation address 0.
    assign w_pipeIn = {r_rdEn, r_rdEn && (r_p2Addr == '0)};

    fc_valid_pipe #(
        .DEPTH (MEM_LAT)
    ) u_validPipe (
        .clk    (clk),
        .reset  (reset),
        .i_din  (w_pipeIn),
        .o_dout (w_pipeOut)
    );

    // Sequencer FSM: state, counters and all registered outputs move together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_i       <= '0;
            r_n       <= '0;
            r_drain   <= '0;
            r_rdEn    <= 1'b0;
            r_p2Addr  <= '0;
            r_wAddr   <= '0;
            r_outWr   <= 1'b0;
            r_outAddr <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_outWr <= 1'b0;
            unique case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state  <= READ;
                        r_i      <= '0;
                        r_n      <= '0;
                        r_rdEn   <= 1'b1;
                        r_p2Addr <= '0;
                        r_wAddr  <= '0;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                    end
                end
                READ: begin
                    if (r_i == P2_AW'(N_IN - 1)) begin
                        r_i     <= '0;
                        r_drain <= '0;
                        r_rdEn  <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        r_i      <= w_nextI;
                        r_p2Addr <= w_nextI;
                        r_wAddr  <= w_nextWAddr;
                    end
                end
                DRAIN: begin
                    if (r_drain == 2'(MEM_LAT - 1)) begin
                        r_state   <= WRITE;
                        r_outWr   <= 1'b1;
                        r_outAddr <= r_n;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                WRITE: begin
                    if (r_n == OUT_AW'(N_OUT - 1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_n      <= r_n + 1'b1;
                        r_state  <= READ;
                        r_rdEn   <= 1'b1;
                        r_p2Addr <= '0;
                        r_wAddr  <= w_nextRowAddr;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.p2_addr  = r_p2Addr;
    assign bus.w_addr   = r_wAddr;
    assign bus.rd_en    = r_rdEn;
    assign bus.acc_en   = w_pipeOut[1];
    assign bus.acc_clr  = w_pipeOut[0];
    assign bus.out_wr   = r_outWr;
    assign bus.out_addr = r_outAddr;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
